fml_ram_responder: RTL

FML_RAM_RESPONDER -- requirements
Module: fml_ram_responder

---
 rtl/fml_ram_responder.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/fml_ram_responder.sv
// FML burst responder backed by an on-chip RAM of 2**mem_depth 32-bit words.
// Four-beat bursts, 16-byte aligned. The ack comes `latency` cycles after the
// request is sampled. The data beats follow, and then one turnaround cycle.
// Optional macro FML_RAM_RANGE_CHECK_EN: bursts whose address lies beyond the
// RAM are acked normally but do not write. Their reads return DEADBEEF, and
// the sticky oor_err flag is set.
// Word index of a beat is {adr[mem_depth+1:4], beat}, so a burst reaches 4 words.
module fml_ram_responder #(
    parameter int unsigned fml_depth = 25,
    parameter int unsigned mem_depth = 10,
    parameter int unsigned latency   = 2
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic [fml_depth-1:0] fml_adr,
    input  logic                 fml_stb,
    input  logic                 fml_we,
    output logic                 fml_ack,
    input  logic [3:0]           fml_sel,
    input  logic [31:0]          fml_di,
    output logic [31:0]          fml_do,
    output logic                 oor_err
);

    localparam int unsigned Words = 2 ** mem_depth;

    typedef enum logic [1:0] {StIdle, StWait, StXfer, StTurn} state_e;

    state_e               state_q, state_d;
    logic [mem_depth-1:0] word_q, word_d;   // first word of the burst, beat bits 0
    logic                 we_q, we_d;
    logic                 oor_q, oor_d;     // current burst is out of range
    logic                 err_q, err_d;     // sticky out-of-range flag
    logic [3:0]           cnt_q, cnt_d;
    logic [1:0]           beat_q, beat_d;
    logic [31:0]          do_q;

    logic [31:0]          mem [Words];

    logic                 accept;
    logic                 wr_en;
    logic                 rd_en;
    logic [1:0]           wr_beat;
    logic [1:0]           rd_beat;
    logic [mem_depth-1:0] wr_idx;
    logic [mem_depth-1:0] rd_idx;
    logic                 adr_oor;

`ifdef FML_RAM_RANGE_CHECK_EN
    logic unused_sig;
    assign adr_oor    = |fml_adr[fml_depth-1:mem_depth+2];
    assign oor_err    = err_q;
    assign unused_sig = ^fml_adr[1:0];
`else
    logic unused_sig;
    assign adr_oor    = 1'b0;
    assign oor_err    = 1'b0;
    assign unused_sig = ^{fml_adr[1:0], fml_adr[fml_depth-1:mem_depth+2], err_q};
`endif

    assign wr_idx  = word_q | mem_depth'(wr_beat);
    assign rd_idx  = word_q | mem_depth'(rd_beat);
    assign fml_do  = do_q;

    // Next-state, ack, and memory strobes of the burst sequencer
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        we_d    = we_q;
        oor_d   = oor_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        beat_d  = beat_q;
        fml_ack = 1'b0;
        accept  = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_beat = 2'd0;
        rd_beat = 2'd0;

        unique case (state_q)
            StIdle: begin
                accept = fml_stb;
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    // Ack cycle: write beat 0 now, or prefetch read beat 0
                    fml_ack = 1'b1;
                    wr_en   = we_q;
                    rd_en   = ~we_q;
                    beat_d  = 2'd0;
                    state_d = StXfer;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StXfer: begin
                // Writes take beats 1..3 here; reads prefetch the next beat
                wr_beat = beat_q + 2'd1;
                rd_beat = beat_q + 2'd1;
                if (beat_q != 2'd3) begin
                    wr_en  = we_q;
                    rd_en  = ~we_q;
                    beat_d = beat_q + 2'd1;
                end else begin
                    state_d = StTurn;
                end
            end
            StTurn: begin
                // No ack and no data here. A request that is still held is
                // registered on the closing edge, so that back-to-back bursts
                // repeat every latency+5 cycles.
                state_d = StIdle;
                accept  = fml_stb;
            end
            default: state_d = StIdle;
        endcase

        if (accept) begin
            state_d     = StWait;
            word_d      = fml_adr[mem_depth+1:2];
            word_d[1:0] = 2'b00;
            we_d        = fml_we;
            oor_d       = adr_oor;
            cnt_d       = 4'(latency - 1);
            if (adr_oor) begin
                err_d = 1'b1;
            end
        end
    end

    // Sequencer state; reset aborts any burst in flight
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= StIdle;
            word_q  <= '0;
            we_q    <= 1'b0;
            oor_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= 4'd0;
            beat_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            we_q    <= we_d;
            oor_q   <= oor_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
        end
    end

    // Read data register: holds a word only during read beats, otherwise zero
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            do_q <= '0;
        end else if (rd_en) begin
            do_q <= oor_q ? 32'hDEADBEEF : mem[rd_idx];
        end else begin
            do_q <= '0;
        end
    end

    // Byte-masked RAM write; contents survive reset
    always_ff @(posedge sys_clk) begin
        if (wr_en && !oor_q) begin
            for (int k = 0; k < 4; k++) begin
                if (fml_sel[k]) begin
                    mem[wr_idx][8*k +: 8] <= fml_di[8*k +: 8];
                end
            end
        end
    end

endmodule
